// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// No ports; imported by rr_arbiter2 and mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_ICACHE = 1'b0;
  localparam port_id_t PORT_DCACHE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_req          request vector {port1, port0}
//   i_last_grant   port granted most recently
//   o_grant_valid  at least one request is pending
//   o_grant_id     winning port; only meaningful with o_grant_valid
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_t   i_last_grant,
  output logic       o_grant_valid,
  output port_id_t   o_grant_id
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = PORT_ICACHE;
    unique case (i_req)
      2'b01:   o_grant_id = PORT_ICACHE;
      2'b10:   o_grant_id = PORT_DCACHE;
      // Tie: hand the grant to the port that did not win last time.
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = PORT_ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the I-cache refill
// port (port 0) and the D-cache refill/writeback port (port 1). Requests are
// serialised round-robin, issued to memory, and completed with a one-cycle ack.
// A WAIT-state timeout aborts transactions the memory never acknowledges.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   pN_req/we/addr/wdata     requester N command; held until pN_ack
//   pN_ack/err/rdata         one-cycle completion, timeout flag, read data
//   mem_addr/we/wdata        memory command; mem_addr is 0 when idle
//   mem_rdata, mem_ack       memory response
//   busy                     arbiter is not IDLE
// TIMEOUT must be at least 4.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        r_state, w_state_nxt;
  port_id_t          r_last_grant, w_last_grant_nxt;
  port_id_t          r_gnt_id, w_gnt_id_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;

  logic     w_grant_valid;
  port_id_t w_grant_id;
  logic     w_timeout;
  logic     w_resp;

  rr_arbiter2 u_rr (
    .i_req         ({p1_req, p0_req}),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // This WAIT cycle is the TIMEOUT-th one.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_id_nxt     = r_gnt_id;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_rdata_nxt      = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_gnt_id_nxt     = w_grant_id;
          w_last_grant_nxt = w_grant_id;
          if (w_grant_id == PORT_DCACHE) begin
            w_we_nxt    = p1_we;
            w_addr_nxt  = p1_addr;
            w_wdata_nxt = p1_wdata;
          end else begin
            w_we_nxt    = p0_we;
            w_addr_nxt  = p0_addr;
            w_wdata_nxt = p0_wdata;
          end
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A memory ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          w_rdata_nxt = mem_rdata;
          w_err_nxt   = 1'b0;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_DCACHE;
      r_gnt_id     <= PORT_ICACHE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_rdata      <= w_rdata_nxt;
    end
  end

  // The address drops to 0 in the very cycle WAIT ends so the memory sees an
  // address-0 gap before any later read and never restarts on its own.
  always_comb begin
    mem_addr = '0;
    if (r_state == ISSUE) begin
      mem_addr = r_addr;
    end else if (r_state == WAIT && !mem_ack && !w_timeout) begin
      mem_addr = r_addr;
    end
  end

  assign mem_we    = (r_state == ISSUE) & r_we;
  assign mem_wdata = (r_state == ISSUE) ? r_wdata : '0;
  assign busy      = (r_state != IDLE);

  assign w_resp   = (r_state == RESP);
  assign p0_ack   = w_resp & (r_gnt_id == PORT_ICACHE);
  assign p1_ack   = w_resp & (r_gnt_id == PORT_DCACHE);
  assign p0_err   = p0_ack & r_err;
  assign p1_err   = p1_ack & r_err;
  assign p0_rdata = p0_ack ? r_rdata : '0;
  assign p1_rdata = p1_ack ? r_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single-ported, variable-latency main memory between the instruction-cache refill port (port 0) and the data-cache refill/writeback port (port 1).
It serializes requests with round-robin fairness and drives the memory's one-cycle write strobe and address-qualified read start. It waits for the memory acknowledge, then returns data and a one-cycle acknowledge to the winning requester.
A timeout catches transactions the memory never acknowledges, e.g. a read of address 0, which the memory does not start.

Parameters:
ADDR_W, 32, address width on both requester ports and the memory port
DATA_W, 32, data width
TIMEOUT, 16, cycles allowed in WAIT before the transaction is aborted with error; must be >= 4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
p0_req  in  1  port 0 request; level, held until p0_ack
p0_we  in  1  port 0 write (1) / read (0); stable while p0_req
p0_addr  in  ADDR_W  port 0 byte address; stable while p0_req
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_err  out  1  valid with p0_ack; 1 = timed out
p0_rdata  out  DATA_W  read data, valid with p0_ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0, for port 1
mem_addr  out  ADDR_W  memory address; 0 whenever no transaction is active
mem_we  out  1  memory write strobe; exactly one cycle per write
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ack  in  1  memory completion
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- All outputs 0.
- State IDLE.
- last_grant = 1, so port 0 wins the first tie.
- Timeout counter 0.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- No request pending: stay in IDLE.
- Exactly one req high: grant that port.
- Both req high: grant the port that is not last_grant.
- On a grant: latch the port's we, addr and wdata, set last_grant to that port, go to ISSUE.

ISSUE (1 cycle):
- mem_addr = latched addr.
- mem_we = latched we.
- mem_wdata = latched wdata.
- Timeout counter is cleared.
- Go to WAIT.

WAIT:
- mem_we = 0; mem_addr holds the latched address.
- Counter increments every cycle.
- mem_ack = 1: capture mem_rdata, force mem_addr to 0 in that same cycle, go to RESP with err = 0.
- Otherwise, counter reaching TIMEOUT: force mem_addr to 0, go to RESP with err = 1 and rdata = 0.
- mem_ack takes priority over timeout if both occur in the same cycle.

RESP (1 cycle):
- Granted port's ack = 1; err and rdata are valid.
- mem_addr = 0.
- Go to IDLE.
- The requester must deassert req in the cycle after ack. A req still high then is treated as a new request.

Latency:
- Grant to memory issue: 1 cycle.
- Minimum request-to-ack: 3 cycles plus memory latency.
- Back-to-back transactions have one idle cycle between RESP and the next ISSUE. This guarantees the memory sees address 0 for at least one cycle and does not self-restart.

Other rules:
- Requests that arrive while busy wait for IDLE; they are not queued beyond the req level.
- mem_ack seen outside WAIT is ignored.
- A requester dropping req mid-transaction has no effect: the transaction completes and the ack is still pulsed.
- Reset mid-transaction: outputs clear immediately, including mem_addr = 0 and mem_we = 0, and the state returns to IDLE. A memory operation already started completes unobserved.
- A read of address 0 always ends with err = 1 after TIMEOUT cycles in WAIT. A write to address 0 completes normally, since the memory starts writes on mem_we.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef logic port_id_t
  - localparam PORT_ICACHE = 0, PORT_DCACHE = 1
- Sub-module rr_arbiter2 is natural:
  - purely combinational grant from {req1, req0} and last_grant
  - outputs grant_valid and grant_id
  - the last_grant register stays in mem_arbiter

Test Plan:
1. After rst, p0 read addr 0x40, memory acks 3 cycles after ISSUE -> one p0_ack pulse with p0_rdata = memory word, p0_err = 0, mem_we never high, mem_addr back to 0 in the ack cycle.
2. p1 write addr 0x80 data 0xDEADBEEF -> mem_we high exactly 1 cycle with mem_addr = 0x80; p1_ack after mem_ack; a later p0 read of 0x80 returns 0xDEADBEEF.
3. p0 and p1 both request reads continuously for 4 transactions -> grants in order p0, p1, p0, p1, with exactly one idle cycle between RESP and the next ISSUE.
4. p0 read addr 0x0, memory never acks -> after TIMEOUT = 16 cycles in WAIT, p0_ack = 1, p0_err = 1, p0_rdata = 0; the arbiter then serves pending p1.
5. Assert rst during WAIT of a p1 write -> mem_addr, mem_we, busy and both acks are 0 immediately; after release, a p0 request is granted first.
6. mem_ack pulse injected while in IDLE, and mem_ack arriving on the same cycle as the timeout -> the former is ignored; the latter completes with err = 0.
